pe_tile_param: RTL and testbench
================================

// Module: pe_tile_param
// PURPOSE
//  Parametrised next-generation PE tile: N-bit datapath, T tracks per side, 4 sides. It holds
//  two connect boxes, a registered switch box and an ALU logic block with optional output
//  register. Adds a config write strobe and 1-cycle config read-back. One tile per grid site.
// PARAMETERS
//  DATA_W      1   bit width of every track and PE operand
//  NUM_TRACKS  4   tracks per side, 1..8
//  CB_SEL_W    $clog2(2*NUM_TRACKS)   connect-box select width (derived, localparam)
// PORTS
//  clk            in   1            rising-edge clock
//  reset          in   1            synchronous, active-high
//  tile_id        in   16           this tile's id
//  config_addr    in   32           [15:0] tile id, [23:16] module id, [31:24] word index
//  config_data    in   32           write data
//  config_write   in   1            write strobe, one cycle per word
//  config_read    in   1            read strobe
//  read_data      out  32           read-back word
//  read_valid     out  1            read_data valid
//  in_wires       in   4*T*DATA_W   side s, track t at [((s*T+t)*DATA_W) +: DATA_W]
//  out_wires      out  4*T*DATA_W   same packing
// BEHAVIOUR
//  Address match: hit = addr[15:0]==tile_id; module ids are LB=4, CB1=5, CB0=6, SB=7.
//   Any other id, or word index out of range, is ignored on write and reads as 0.
//  Config regs are written on clk when config_write & hit. Reset clears all of them to 0.
//  SB word w (0..3) sets side w. Per track t, bits [3t+1:3t] give sel, bit 3t+2 gives reg_en.
//   sel 0/1/2 picks the same track t from the other sides in ascending side order,
//   skipping side w. sel 3 picks pe_out.
//  SB output: reg_en=0 gives combinational mux out. reg_en=1 gives a flop, cleared on reset.
//  CB0 (word 0, bits [CB_SEL_W-1:0]) picks op_a: idx<T gives in side0 track idx,
//   else out side0 track idx-T. CB1 does the same for side 1 and gives op_b.
//  LB word 0: [2:0] opcode (0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 PASS_A, 6 NOT_A, 7 zero),
//   [3] out_reg. Arithmetic is modulo 2^DATA_W and the carry is dropped.
//  pe_out is combinational when out_reg=0, else a flop with 1-cycle latency, reset to 0.
//  Combinational loop via CB reading out_wires: legal only if the path is registered in SB
//   or LB. Software guarantees this. RTL does not check it.
//  Read: config_read & hit gives read_data = addressed reg (zero-extended) on the next cycle,
//   with read_valid=1 for that one cycle. A miss still asserts read_valid with data 0.
//  Write and read in the same cycle to the same word: the read returns the OLD value.
//  Reset outputs: out_wires=0, read_data=0, read_valid=0, pe_out=0, all config=0.
//  Reset asserted mid-operation wins over config_write in the same cycle.
// STRUCTURE
//  pe_tile_pkg: module-id constants, opcode enum, SB field offsets, ALU function.
//  Sub-module sb_track_mux (DATA_W): 4:1 mux plus optional output flop, one per out track.
//   The switch box is a generate loop of 4*NUM_TRACKS instances.
//  CB muxes and the ALU are inline. The config/read-back register file lives in the top.
// TESTING (DATA_W=8, NUM_TRACKS=4, tile_id=16'h0003)
//  1. Reset: after reset, all out_wires=0 and read_valid=0. Read SB word 2 gives read_data=0.
//  2. Write LB=0x0 (ADD, comb). CB0 sel=1, CB1 sel=2. Drive in s0t1=8'hF0, s1t2=8'h20.
//     Write SB word 3 t0 sel=3, reg_en=0 -> out s3t0=8'h10 the same cycle (wrap).
//  3. Set LB out_reg=1 and SB reg_en=1 -> out s3t0 updates exactly 2 cycles after the input
//     change.
//  4. Write with tile_id mismatch (addr[15:0]=4): config unchanged, and a read returns the old
//     value with read_valid=1.
//  5. Same-cycle write 0x5 and read of LB -> read_data is the old 0x8. The next read gives 0x5.
//  6. Assert reset while SB reg_en=1 is driving 8'hAA -> out=0 on the next edge, and config
//     is cleared.

Source files
------------

// File: rtl/pe_tile_pkg.sv
// Shared constants, opcode encoding and ALU function for the PE tile.
// The ALU works at 32 bits; callers truncate to their datapath width.
package pe_tile_pkg;

   localparam logic [7:0] MOD_LB  = 8'd4;
   localparam logic [7:0] MOD_CB1 = 8'd5;
   localparam logic [7:0] MOD_CB0 = 8'd6;
   localparam logic [7:0] MOD_SB  = 8'd7;

   localparam int SB_WORDS   = 4;
   localparam int SB_FIELD_W = 3;
   localparam int SB_SEL_LSB = 0;
   localparam int SB_REG_EN  = 2;
   localparam int LB_W       = 4;
   localparam int LB_OUT_REG = 3;

   typedef enum logic [2:0] {
      OP_ADD    = 3'd0,
      OP_SUB    = 3'd1,
      OP_AND    = 3'd2,
      OP_OR     = 3'd3,
      OP_XOR    = 3'd4,
      OP_PASS_A = 3'd5,
      OP_NOT_A  = 3'd6,
      OP_ZERO   = 3'd7
   } op_e;

   function automatic logic [31:0] alu_f(input op_e op, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [31:0] r;
      r = '0;
      case (op)
         OP_ADD:    r = a + b;
         OP_SUB:    r = a - b;
         OP_AND:    r = a & b;
         OP_OR:     r = a | b;
         OP_XOR:    r = a ^ b;
         OP_PASS_A: r = a;
         OP_NOT_A:  r = ~a;
         default:   r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/sb_track_mux.sv
// One switch-box output track: 4:1 select with an optional output flop.
module sb_track_mux
   import pe_tile_pkg::*;
#(
   parameter int DATA_W = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in0,
   input  logic [DATA_W-1:0] in1,
   input  logic [DATA_W-1:0] in2,
   input  logic [DATA_W-1:0] in3,
   input  logic [1:0]        sel,
   input  logic              reg_en,
   output logic [DATA_W-1:0] out
);

   logic [DATA_W-1:0] mux;
   logic [DATA_W-1:0] q;

   always_comb begin
      mux = in0;
      case (sel)
         2'd0: mux = in0;
         2'd1: mux = in1;
         2'd2: mux = in2;
         2'd3: mux = in3;
         default: mux = in0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) q <= '0;
      else       q <= mux;
   end

   assign out = reg_en ? q : mux;

endmodule

// File: rtl/pe_tile_param.sv
// PE tile: config register file with read-back, two connect boxes, ALU with
// optional output register, and a per-track switch box.
module pe_tile_param
   import pe_tile_pkg::*;
#(
   parameter int DATA_W     = 1,
   parameter int NUM_TRACKS = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [15:0]                    tile_id,
   input  logic [31:0]                    config_addr,
   input  logic [31:0]                    config_data,
   input  logic                           config_write,
   input  logic                           config_read,
   output logic [31:0]                    read_data,
   output logic                           read_valid,
   input  logic [4*NUM_TRACKS*DATA_W-1:0] in_wires,
   output logic [4*NUM_TRACKS*DATA_W-1:0] out_wires
);

   localparam int T        = NUM_TRACKS;
   localparam int CB_SEL_W = $clog2(2*NUM_TRACKS);
   localparam int SB_W     = SB_FIELD_W*T;

   logic              hit;
   logic [7:0]        mod_id;
   logic [7:0]        word;
   logic [SB_W-1:0]   sb_cfg [SB_WORDS];
   logic [CB_SEL_W-1:0] cb0_cfg;
   logic [CB_SEL_W-1:0] cb1_cfg;
   logic [LB_W-1:0]   lb_cfg;
   logic [31:0]       rd_word;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic [DATA_W-1:0] pe_comb;
   logic [DATA_W-1:0] pe_q;
   logic [DATA_W-1:0] pe_out;
   logic              unused_cfg;

   assign hit    = (config_addr[15:0] == tile_id);
   assign mod_id = config_addr[23:16];
   assign word   = config_addr[31:24];

   // Widest field is the SB word; bits above it have no storage.
   assign unused_cfg = ^config_data[31:SB_W];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < SB_WORDS; i++) sb_cfg[i] <= '0;
         cb0_cfg <= '0;
         cb1_cfg <= '0;
         lb_cfg  <= '0;
      end else if (config_write && hit) begin
         case (mod_id)
            MOD_SB:  if (word < 8'(SB_WORDS)) sb_cfg[word[1:0]] <= config_data[SB_W-1:0];
            MOD_CB0: if (word == 8'd0) cb0_cfg <= config_data[CB_SEL_W-1:0];
            MOD_CB1: if (word == 8'd0) cb1_cfg <= config_data[CB_SEL_W-1:0];
            MOD_LB:  if (word == 8'd0) lb_cfg  <= config_data[LB_W-1:0];
            default: ;
         endcase
      end
   end

   always_comb begin
      rd_word = '0;
      if (hit) begin
         case (mod_id)
            MOD_SB:  if (word < 8'(SB_WORDS)) rd_word = 32'(sb_cfg[word[1:0]]);
            MOD_CB0: if (word == 8'd0) rd_word = 32'(cb0_cfg);
            MOD_CB1: if (word == 8'd0) rd_word = 32'(cb1_cfg);
            MOD_LB:  if (word == 8'd0) rd_word = 32'(lb_cfg);
            default: rd_word = '0;
         endcase
      end
   end

   // Read samples the pre-write register value, so a same-cycle write is not visible.
   always_ff @(posedge clk) begin
      if (reset) begin
         read_data  <= '0;
         read_valid <= 1'b0;
      end else begin
         read_data  <= config_read ? rd_word : '0;
         read_valid <= config_read;
      end
   end

   // Select values >= T tap this tile's own outputs on the same side.
   always_comb begin
      op_a = '0;
      if (int'(cb0_cfg) < T)
         op_a = in_wires[int'(cb0_cfg)*DATA_W +: DATA_W];
      else if (int'(cb0_cfg) < 2*T)
         op_a = out_wires[(int'(cb0_cfg)-T)*DATA_W +: DATA_W];
   end

   always_comb begin
      op_b = '0;
      if (int'(cb1_cfg) < T)
         op_b = in_wires[(T+int'(cb1_cfg))*DATA_W +: DATA_W];
      else if (int'(cb1_cfg) < 2*T)
         op_b = out_wires[int'(cb1_cfg)*DATA_W +: DATA_W];
   end

   assign pe_comb = DATA_W'(alu_f(op_e'(lb_cfg[2:0]), 32'(op_a), 32'(op_b)));

   always_ff @(posedge clk) begin
      if (reset) pe_q <= '0;
      else       pe_q <= pe_comb;
   end

   assign pe_out = lb_cfg[LB_OUT_REG] ? pe_q : pe_comb;

   // Switch box: sel 0..2 walk the other three sides in ascending order.
   for (genvar s = 0; s < 4; s++) begin : g_side
      localparam int O0 = (s == 0) ? 1 : 0;
      localparam int O1 = (s <= 1) ? 2 : 1;
      localparam int O2 = (s <= 2) ? 3 : 2;
      for (genvar t = 0; t < T; t++) begin : g_trk
         sb_track_mux #(.DATA_W(DATA_W)) u_mux (
            .clk    (clk),
            .reset  (reset),
            .in0    (in_wires[(O0*T+t)*DATA_W +: DATA_W]),
            .in1    (in_wires[(O1*T+t)*DATA_W +: DATA_W]),
            .in2    (in_wires[(O2*T+t)*DATA_W +: DATA_W]),
            .in3    (pe_out),
            .sel    (sb_cfg[s][SB_FIELD_W*t+SB_SEL_LSB +: 2]),
            .reg_en (sb_cfg[s][SB_FIELD_W*t+SB_REG_EN]),
            .out    (out_wires[(s*T+t)*DATA_W +: DATA_W])
         );
      end
   end

endmodule

// File: tb/tb_pe_tile_param.sv
// Bench for pe_tile_param (DATA_W=8, 4 tracks): directed scenarios plus a
// randomized run against a cycle-level reference model of the tile.
module tb_pe_tile_param;

   localparam int DW = 8;
   localparam int T  = 4;
   localparam int NW = 4*T*DW;

   logic          clk = 1'b0;
   logic          reset;
   logic [15:0]   tile_id = 16'h0003;
   logic [31:0]   config_addr;
   logic [31:0]   config_data;
   logic          config_write;
   logic          config_read;
   logic [31:0]   read_data;
   logic          read_valid;
   logic [NW-1:0] in_wires;
   logic [NW-1:0] out_wires;

   int total = 0;
   int bad   = 0;

   pe_tile_param #(.DATA_W(DW), .NUM_TRACKS(T)) dut (
      .clk          (clk),
      .reset        (reset),
      .tile_id      (tile_id),
      .config_addr  (config_addr),
      .config_data  (config_data),
      .config_write (config_write),
      .config_read  (config_read),
      .read_data    (read_data),
      .read_valid   (read_valid),
      .in_wires     (in_wires),
      .out_wires    (out_wires)
   );

   always #5 clk = ~clk;

   // reference model state
   int          m_sb [4];
   int          m_cb0, m_cb1, m_lb;
   logic [7:0]  m_peq;
   logic [7:0]  m_sbq [4][T];
   logic [31:0] m_rd;
   logic        m_rv;
   logic [7:0]  e_mux [4][T];
   logic [7:0]  e_alu;
   logic [NW-1:0] exp_ow;

   function automatic logic [7:0] ref_alu(int op, logic [7:0] a, logic [7:0] b);
      case (op)
         0: return a + b;
         1: return a - b;
         2: return a & b;
         3: return a | b;
         4: return a ^ b;
         5: return a;
         6: return ~a;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [31:0] cfg_val(logic [31:0] addr);
      int md, wd;
      if (addr[15:0] != tile_id) return 32'h0;
      md = int'(addr[23:16]);
      wd = int'(addr[31:24]);
      if (md == 7 && wd < 4)  return 32'(m_sb[wd]);
      if (md == 6 && wd == 0) return 32'(m_cb0);
      if (md == 5 && wd == 0) return 32'(m_cb1);
      if (md == 4 && wd == 0) return 32'(m_lb);
      return 32'h0;
   endfunction

   // Fixed-point evaluation of the combinational tile given model state and inputs.
   task automatic eval();
      logic [7:0] ow [4][T];
      logic [7:0] opa, opb, pe;
      int sel, en, src;
      for (int s = 0; s < 4; s++)
         for (int t = 0; t < T; t++) ow[s][t] = 8'h00;
      for (int it = 0; it < 3; it++) begin
         opa = (m_cb0 < T) ? in_wires[m_cb0*DW +: DW] : ow[0][m_cb0-T];
         opb = (m_cb1 < T) ? in_wires[(T+m_cb1)*DW +: DW] : ow[1][m_cb1-T];
         e_alu = ref_alu(m_lb & 7, opa, opb);
         pe = ((m_lb & 8) != 0) ? m_peq : e_alu;
         for (int s = 0; s < 4; s++) begin
            for (int t = 0; t < T; t++) begin
               sel = (m_sb[s] >> (3*t)) & 3;
               en  = (m_sb[s] >> (3*t+2)) & 1;
               src = (sel < s) ? sel : sel + 1;
               e_mux[s][t] = (sel == 3) ? pe : in_wires[(src*T+t)*DW +: DW];
               ow[s][t] = (en != 0) ? m_sbq[s][t] : e_mux[s][t];
            end
         end
      end
      for (int s = 0; s < 4; s++)
         for (int t = 0; t < T; t++) exp_ow[(s*T+t)*DW +: DW] = ow[s][t];
   endtask

   task automatic tick();
      logic [7:0]  n_sbq [4][T];
      logic [7:0]  n_pe;
      logic [31:0] n_rd;
      logic        n_rv, rst;
      int n_sb [4];
      int n_cb0, n_cb1, n_lb, md, wd;
      eval();
      n_sbq = e_mux;
      n_pe  = e_alu;
      n_rv  = config_read;
      n_rd  = config_read ? cfg_val(config_addr) : 32'h0;
      n_sb  = m_sb;
      n_cb0 = m_cb0;
      n_cb1 = m_cb1;
      n_lb  = m_lb;
      if (config_write && config_addr[15:0] == tile_id) begin
         md = int'(config_addr[23:16]);
         wd = int'(config_addr[31:24]);
         if (md == 7 && wd < 4)  n_sb[wd] = int'(config_data & 32'hFFF);
         if (md == 6 && wd == 0) n_cb0 = int'(config_data & 32'h7);
         if (md == 5 && wd == 0) n_cb1 = int'(config_data & 32'h7);
         if (md == 4 && wd == 0) n_lb  = int'(config_data & 32'hF);
      end
      rst = reset;
      @(posedge clk);
      if (rst) begin
         for (int s = 0; s < 4; s++) begin
            m_sb[s] = 0;
            for (int t = 0; t < T; t++) m_sbq[s][t] = 8'h00;
         end
         m_cb0 = 0; m_cb1 = 0; m_lb = 0;
         m_peq = 8'h00; m_rd = 32'h0; m_rv = 1'b0;
      end else begin
         m_sb = n_sb; m_cb0 = n_cb0; m_cb1 = n_cb1; m_lb = n_lb;
         m_sbq = n_sbq; m_peq = n_pe; m_rd = n_rd; m_rv = n_rv;
      end
      #1;
      eval();
   endtask

   task automatic cfg_wr(int md, int wd, logic [31:0] data, logic [15:0] tid);
      config_addr  = {8'(wd), 8'(md), tid};
      config_data  = data;
      config_write = 1'b1;
      tick();
      config_write = 1'b0;
   endtask

   task automatic cfg_rd(int md, int wd, logic [15:0] tid);
      config_addr = {8'(wd), 8'(md), tid};
      config_read = 1'b1;
      tick();
      config_read = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      in_wires = '0;
      config_addr = '0; config_data = '0;
      config_write = 1'b0; config_read = 1'b0;
      tick(); tick();
      reset = 1'b0;
      total++;
      if (out_wires !== '0) begin
         bad++; $display("FAIL reset_out: got %h want 0", out_wires);
      end
      total++;
      if (read_valid !== 1'b0) begin
         bad++; $display("FAIL reset_rv: got %b want 0", read_valid);
      end
      total++;
      if (read_data !== 32'h0) begin
         bad++; $display("FAIL reset_rd: got %h want 0", read_data);
      end
      cfg_rd(7, 2, tile_id);
      total++;
      if (read_valid !== 1'b1 || read_data !== 32'h0) begin
         bad++; $display("FAIL reset_sb2: got v=%b d=%h want v=1 d=0", read_valid, read_data);
      end
   endtask

   task automatic test_add_wrap();
      cfg_wr(4, 0, 32'h0, tile_id);
      cfg_wr(6, 0, 32'h1, tile_id);
      cfg_wr(5, 0, 32'h2, tile_id);
      in_wires = '0;
      in_wires[1*DW +: DW] = 8'hF0;
      in_wires[(T+2)*DW +: DW] = 8'h20;
      cfg_wr(7, 3, 32'h3, tile_id);
      total++;
      if (out_wires[(3*T)*DW +: DW] !== 8'h10) begin
         bad++; $display("FAIL add_wrap: got %h want 10", out_wires[(3*T)*DW +: DW]);
      end
      total++;
      if (out_wires !== exp_ow) begin
         bad++; $display("FAIL add_model: got %h want %h", out_wires, exp_ow);
      end
   endtask

   task automatic test_reg_latency();
      cfg_wr(4, 0, 32'h8, tile_id);
      cfg_wr(7, 3, 32'h7, tile_id);
      tick(); tick();
      total++;
      if (out_wires[(3*T)*DW +: DW] !== 8'h10) begin
         bad++; $display("FAIL lat_settle: got %h want 10", out_wires[(3*T)*DW +: DW]);
      end
      in_wires[1*DW +: DW] = 8'h01;
      tick();
      total++;
      if (out_wires[(3*T)*DW +: DW] !== 8'h10) begin
         bad++; $display("FAIL lat_cycle1: got %h want 10", out_wires[(3*T)*DW +: DW]);
      end
      tick();
      total++;
      if (out_wires[(3*T)*DW +: DW] !== 8'h21) begin
         bad++; $display("FAIL lat_cycle2: got %h want 21", out_wires[(3*T)*DW +: DW]);
      end
   endtask

   task automatic test_miss();
      cfg_wr(4, 0, 32'h5, 16'h0004);
      cfg_rd(4, 0, tile_id);
      total++;
      if (read_valid !== 1'b1 || read_data !== 32'h8) begin
         bad++; $display("FAIL miss_keep: got v=%b d=%h want v=1 d=8", read_valid, read_data);
      end
      cfg_rd(4, 0, 16'h0004);
      total++;
      if (read_valid !== 1'b1 || read_data !== 32'h0) begin
         bad++; $display("FAIL miss_read: got v=%b d=%h want v=1 d=0", read_valid, read_data);
      end
      cfg_rd(9, 0, tile_id);
      total++;
      if (read_valid !== 1'b1 || read_data !== 32'h0) begin
         bad++; $display("FAIL bad_mod: got v=%b d=%h want v=1 d=0", read_valid, read_data);
      end
      cfg_rd(7, 4, tile_id);
      total++;
      if (read_valid !== 1'b1 || read_data !== 32'h0) begin
         bad++; $display("FAIL bad_word: got v=%b d=%h want v=1 d=0", read_valid, read_data);
      end
      total++;
      if (read_valid === 1'b1) begin
         tick();
         if (read_valid !== 1'b0) begin
            bad++; $display("FAIL rv_pulse: got %b want 0", read_valid);
         end
      end else begin
         bad++; $display("FAIL rv_pulse: read_valid low before pulse check");
      end
   endtask

   task automatic test_same_cycle();
      config_addr  = {8'd0, 8'd4, tile_id};
      config_data  = 32'h5;
      config_write = 1'b1;
      config_read  = 1'b1;
      tick();
      config_write = 1'b0;
      config_read  = 1'b0;
      total++;
      if (read_valid !== 1'b1 || read_data !== 32'h8) begin
         bad++; $display("FAIL rw_old: got v=%b d=%h want v=1 d=8", read_valid, read_data);
      end
      cfg_rd(4, 0, tile_id);
      total++;
      if (read_data !== 32'h5) begin
         bad++; $display("FAIL rw_new: got %h want 5", read_data);
      end
   endtask

   task automatic test_random();
      int act, md, wd;
      logic [31:0] d;
      logic [15:0] tid;
      for (int i = 0; i < 400; i++) begin
         in_wires = {$urandom(), $urandom(), $urandom(), $urandom()};
         act = $urandom_range(0, 9);
         config_write = 1'b0;
         config_read  = 1'b0;
         md  = $urandom_range(3, 8);
         wd  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5)
                                           : ((md == 7) ? $urandom_range(0, 3) : 0);
         tid = ($urandom_range(0, 7) == 0) ? (tile_id ^ 16'h0001) : tile_id;
         d   = $urandom();
         // keep any out_wires feedback through a CB broken by the LB register
         if (md == 4 && (m_cb0 >= T || m_cb1 >= T)) d[3] = 1'b1;
         if ((md == 5 || md == 6) && (m_lb & 8) == 0) d[2] = 1'b0;
         config_addr = {8'(wd), 8'(md), tid};
         config_data = d;
         if (act <= 3) config_write = 1'b1;
         if (act >= 2 && act <= 5) config_read = 1'b1;
         tick();
         total++;
         if (out_wires !== exp_ow) begin
            bad++; $display("FAIL rnd_out[%0d]: got %h want %h", i, out_wires, exp_ow);
         end
         total++;
         if (read_valid !== m_rv || read_data !== m_rd) begin
            bad++;
            $display("FAIL rnd_rd[%0d]: got v=%b d=%h want v=%b d=%h",
                     i, read_valid, read_data, m_rv, m_rd);
         end
      end
      config_write = 1'b0;
      config_read  = 1'b0;
   endtask

   task automatic test_reset_mid();
      cfg_wr(6, 0, 32'h0, tile_id);
      cfg_wr(5, 0, 32'h0, tile_id);
      cfg_wr(4, 0, 32'h5, tile_id);
      in_wires = '0;
      in_wires[0 +: DW] = 8'hAA;
      cfg_wr(7, 3, 32'h7, tile_id);
      tick();
      total++;
      if (out_wires[(3*T)*DW +: DW] !== 8'hAA) begin
         bad++; $display("FAIL mid_pre: got %h want aa", out_wires[(3*T)*DW +: DW]);
      end
      reset = 1'b1;
      in_wires = '0;
      config_addr  = {8'd0, 8'd4, tile_id};
      config_data  = 32'h3;
      config_write = 1'b1;
      tick();
      reset = 1'b0;
      config_write = 1'b0;
      total++;
      if (out_wires !== '0) begin
         bad++; $display("FAIL mid_out: got %h want 0", out_wires);
      end
      cfg_rd(7, 3, tile_id);
      total++;
      if (read_data !== 32'h0) begin
         bad++; $display("FAIL mid_sb3: got %h want 0", read_data);
      end
      cfg_rd(4, 0, tile_id);
      total++;
      if (read_data !== 32'h0) begin
         bad++; $display("FAIL mid_lb: got %h want 0", read_data);
      end
   endtask

   initial begin
      test_reset();
      test_add_wrap();
      test_reg_latency();
      test_miss();
      test_same_cycle();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
